// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART file loader: FSM encoding, protocol control bytes
// and the lane-strobe helper used by the byte packer.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SIZE = 3'd2,
    ST_DATA = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] FILE_REQ  = 8'h02;
  localparam logic [7:0] FILE_SEND = 8'h03;
  localparam logic [7:0] FILE_END  = 8'h04;

  localparam int WORD_BYTES = 4;

  // Byte enables for lanes 0..last_lane inclusive.
  function automatic logic [3:0] lane_strb(input logic [1:0] last_lane);
    return 4'((5'd2 << last_lane) - 5'd1);
  endfunction

endpackage

// File: rtl/uart_file_loader_if.sv
// Bus bundle between the loader and its environment: UART tx/rx byte streams and the
// memory write port. Every channel transfers on a cycle where valid && ready.
interface uart_file_loader_if #(
  parameter int ADDR_W = 18
) ();

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_valid;
  logic              mem_ready;

  modport master (
    output tx_data, tx_valid, rx_ready, mem_addr, mem_wdata, mem_wstrb, mem_valid,
    input  tx_ready, rx_data, rx_valid, mem_ready
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, mem_addr, mem_wdata, mem_wstrb, mem_valid,
    output tx_ready, rx_data, rx_valid, mem_ready
  );

endinterface

// File: rtl/uart_loader_packer.sv
// Packs accepted payload bytes into little-endian 32-bit words and reports, on the
// completing byte, the merged word and its byte-enable strobe.
module uart_loader_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_done,
  output logic [31:0] word_data,
  output logic [3:0]  word_strb
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;

  always_comb begin
    // Upper lanes of acc_q are always zero, so a partial word reads 0 there.
    word_data = acc_q;
    word_data[8*lane_q +: 8] = byte_data;
    word_done = byte_valid && ((lane_q == 2'(WORD_BYTES - 1)) || byte_last);
    word_strb = lane_strb(lane_q);

    lane_d = lane_q;
    acc_d  = acc_q;
    if (clear) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (byte_valid) begin
      if (word_done) begin
        lane_d = '0;
        acc_d  = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        acc_d  = word_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/uart_file_loader.sv
// UART file loader: sends FILE_REQ, captures a 4-byte LE size, writes the payload as LE
// words from address 0. Define LOADER_CHKSUM_EN to add the payload byte-sum output chksum.
module uart_file_loader
  import uart_loader_pkg::*;
#(
  parameter int              ADDR_W    = 18,
  parameter longint unsigned MAX_BYTES = 64'd1 << (ADDR_W + 2)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  uart_file_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [31:0]        file_size,
`ifdef LOADER_CHKSUM_EN
  output logic [31:0]        chksum,
`endif
  output state_t             dbg_state
);

  state_t            state_q, state_d;
  logic [1:0]        size_idx_q, size_idx_d;
  logic [31:0]       file_size_q, file_size_d;
  logic [31:0]       byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              error_q, error_d;

  logic        rx_ready;
  logic        start_acc;
  logic        data_fire;
  logic        byte_last;
  logic [31:0] size_next;
  logic        pk_done;
  logic [31:0] pk_word;
  logic [3:0]  pk_strb;

  assign rx_ready  = (state_q == ST_SIZE) || (state_q == ST_DATA);
  assign start_acc = (state_q == ST_IDLE) && start;
  assign data_fire = (state_q == ST_DATA) && bus.rx_valid;
  assign byte_last = ((byte_cnt_q + 32'd1) == file_size_q);

  uart_loader_packer u_packer (
    .clk        (clk),
    .rst_n      (resetn),
    .clear      (start_acc),
    .byte_valid (data_fire),
    .byte_data  (bus.rx_data),
    .byte_last  (byte_last),
    .word_done  (pk_done),
    .word_data  (pk_word),
    .word_strb  (pk_strb)
  );

  always_comb begin
    state_d     = state_q;
    size_idx_d  = size_idx_q;
    file_size_d = file_size_q;
    byte_cnt_d  = byte_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    error_d     = error_q;

    size_next = file_size_q;
    size_next[8*size_idx_q +: 8] = bus.rx_data;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d    = ST_REQ;
          size_idx_d = '0;
          byte_cnt_d = '0;
          mem_addr_d = '0;
          error_d    = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.tx_ready) state_d = ST_SIZE;
      end
      ST_SIZE: begin
        if (bus.rx_valid) begin
          file_size_d = size_next;
          size_idx_d  = size_idx_q + 2'd1;
          if (size_idx_q == 2'd3) begin
            if (size_next == 32'd0) begin
              state_d = ST_DONE;
            end else if ({32'd0, size_next} > MAX_BYTES) begin
              state_d = ST_ERR;
              error_d = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (data_fire) begin
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (pk_done) begin
            mem_wdata_d = pk_word;
            mem_wstrb_d = pk_strb;
            state_d     = ST_WR;
          end
        end
      end
      ST_WR: begin
        // Address advances only on acceptance so it stays stable under backpressure.
        if (bus.mem_ready) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          state_d    = (byte_cnt_q == file_size_q) ? ST_DONE : ST_DATA;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      size_idx_q  <= '0;
      file_size_q <= '0;
      byte_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_idx_q  <= size_idx_d;
      file_size_q <= file_size_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      error_q     <= error_d;
    end
  end

  assign bus.tx_valid  = (state_q == ST_REQ);
  assign bus.tx_data   = (state_q == ST_REQ) ? FILE_REQ : 8'h00;
  assign bus.rx_ready  = rx_ready;
  assign bus.mem_valid = (state_q == ST_WR);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign file_size = file_size_q;
  assign dbg_state = state_q;

`ifdef LOADER_CHKSUM_EN
  logic [31:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    if (start_acc) begin
      chksum_d = '0;
    end else if (data_fire) begin
      chksum_d = chksum_q + {24'd0, bus.rx_data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) chksum_q <= '0;
    else         chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: doc/uart_file_loader.md
# uart_file_loader

Target-side hardware end of the UART file-transfer protocol. It requests a file from the host with control byte 0x02 and receives a 4-byte little-endian size, then that many payload bytes. Payload bytes are packed into 32-bit little-endian words and written to memory starting at word address 0. It sits between the UART core byte stream and a main-memory write port, replacing the firmware boot loader for program and DDR image loads.

## Interface

**Parameters**
- `ADDR_W`, 18: word-address width of the memory port.
- `MAX_BYTES`, 2**(ADDR_W+2): largest accepted file size in bytes.

**Ports**
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `tx_data`, out, 8: byte to the UART transmitter.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: the transmitter accepts the byte.
- `rx_data`, in, 8: byte from the UART receiver.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: the loader accepts the byte.
- `mem_addr`, out, ADDR_W: word address.
- `mem_wdata`, out, 32: write data.
- `mem_wstrb`, out, 4: byte enables.
- `mem_valid`, out, 1: write request.
- `mem_ready`, in, 1: write accepted.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: one-cycle pulse when a load finishes successfully.
- `error`, out, 1: sticky flag for an oversize file. Cleared by the next accepted `start`.
- `file_size`, out, 32: received size, valid from exit of SIZE onward.

## Operation

**States and transitions**
- IDLE → REQ on `start`.
- REQ drives `tx_data`=0x02 and `tx_valid`=1 until `tx_ready`, then → SIZE.
- SIZE accepts 4 bytes: byte k goes to `file_size[8k+7:8k]`, first byte is least significant. After the 4th byte:
  - size 0 → DONE.
  - size > `MAX_BYTES` → ERR.
  - otherwise → DATA.
- DATA accepts payload bytes:
  - Byte n goes to lane n%4: first byte of a word → bits 7:0, fourth byte → bits 31:24.
  - A write is issued after the 4th lane is filled, or after the last byte when `file_size`%4≠0.
  - On a partial last word, `mem_wstrb` covers only the filled lanes and unfilled lanes read 0. A full word uses `mem_wstrb`=4'hF.
- WR holds `mem_valid` until `mem_ready`, then:
  - `mem_addr` increments by 1.
  - → DATA if bytes remain, else → DONE.
- DONE pulses `done` for one cycle, then → IDLE.
- ERR sets `error`, then → IDLE. It performs no memory writes and accepts no further rx bytes.

**Counters and widths**
- Byte counter is 32 bits and compared against `file_size`.
- `mem_addr` wraps modulo 2**ADDR_W. This cannot occur while `MAX_BYTES` ≤ 2**(ADDR_W+2).

**Busy and reset**
- `busy`=1 in every state except IDLE.
- `resetn` low at any time returns to IDLE immediately. No pending write completes and no byte is consumed.

## Timing

- Reset values: `tx_valid`, `rx_ready`, `mem_valid`, `busy`, `done`, `error` all 0. `tx_data`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `file_size` all 0.
- `tx_valid` rises the cycle after `start`. The handshake completes on a cycle where both `tx_valid` and `tx_ready` are high.
- `rx_ready` is 1 only in SIZE and DATA. A byte transfers on `rx_valid`&&`rx_ready`, at most one byte per cycle.
- `rx_ready` is 0 while `mem_valid`=1. There is no write buffering.
- `mem_valid` is registered and rises the cycle after the completing byte. `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_valid`=1 and `mem_ready`=0.
- A full-speed 4-byte word costs 4 accept cycles plus at least 1 write cycle.
- `done` fires the cycle after the final `mem_ready`.
- `start` coincident with `done` is ignored.

## Configuration

- `LOADER_CHKSUM_EN` defined:
  - Adds output port `chksum`, out, 32: the modulo-2**32 sum of all payload bytes, zero-extended.
  - `chksum` clears on accepted `start` and is final when `done` pulses.
- Not defined: the port and the adder are absent. All other behaviour is identical.

## Structure

- Shared package `uart_loader_pkg`:
  - state encoding (IDLE, REQ, SIZE, DATA, WR, DONE, ERR), 3 bits;
  - `FILE_REQ`=8'h02, `FILE_SEND`=8'h03, `FILE_END`=8'h04;
  - `WORD_BYTES`=4.
- Sub-module `uart_loader_packer`: byte-lane shift/merge, lane counter and strobe generation. The FSM, size capture and memory handshake stay in the top level.

## Test plan

1. **Normal 8-byte load.** `start`, host returns size bytes 08 00 00 00 then 11 22 33 44 55 66 77 88.
   - 0x02 is transmitted once.
   - Writes: addr 0 data 0x44332211 strb F, then addr 1 data 0x88776655 strb F.
   - `done` pulses once and `file_size`=8.
2. **Partial last word.** Size 6, bytes AA BB CC DD EE FF.
   - Second write is addr 1 data 0x0000FFEE strb 4'b0011.
3. **Memory backpressure and rx stall.**
   - Hold `mem_ready`=0 for 5 cycles: `mem_*` stays stable and `rx_ready`=0 throughout.
   - No byte is lost or duplicated.
4. **Zero and oversize sizes.**
   - Size 0: `done` with no writes.
   - Size `MAX_BYTES`+1: `error`=1, no writes, `rx_ready`=0.
   - Next `start` clears `error`.
5. **Reset mid-DATA.** Assert `resetn`=0 after 3 payload bytes.
   - All outputs return to reset values asynchronously.
   - A subsequent full load from address 0 succeeds.
6. **`LOADER_CHKSUM_EN` defined.** Scenario 1 → `chksum`=0x00000264 at `done`.
